// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART constants and FSM state encoding shared by TX and RX
package uart_pkg;

    localparam int DEFAULT_CLK_HZ       = 50_000_000;
    localparam int DEFAULT_BAUD         = 115_200;
    localparam int DEFAULT_CLKS_PER_BIT = DEFAULT_CLK_HZ / DEFAULT_BAUD;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_PARITY = 3'd5;
    localparam logic [2:0] ST_STOP   = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        FETCH  = ST_FETCH,
        LOAD   = ST_LOAD,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter, wraps 0..CLKS_PER_BIT-1 and flags the last cycle
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = (CLKS_PER_BIT >= 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bit_tick = !clear && (count == LAST);

endmodule

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmit FSM: pops the TX FIFO and serializes start/data/parity/stop
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Send_TX,
    input  logic                 FIFO_empty,
    input  logic [DATA_BITS-1:0] FIFO_data,
    output logic                 FIFO_read,
    output logic                 TX_busy,
    output logic                 TX,
    output logic                 Tx_done
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 || DATA_BITS < 5 || DATA_BITS > 8) begin : g_param_check
            $error("uart_tx_engine: illegal CLKS_PER_BIT/STOP_BITS/DATA_BITS");
        end
    endgenerate

    uart_state_e          state;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_q;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 baud_clear;
    logic                 bit_tick;

    // Baud counter is held at 0 until the start bit, so every bit is exactly one period
    assign baud_clear = (state == IDLE) || (state == FETCH) || (state == LOAD);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (baud_clear),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            parity_q  <= 1'b0;
            bit_cnt   <= '0;
            FIFO_read <= 1'b0;
            TX_busy   <= 1'b0;
            TX        <= 1'b1;
            Tx_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    TX      <= 1'b1;
                    Tx_done <= 1'b0;
                    if (Send_TX && !FIFO_empty) begin
                        FIFO_read <= 1'b1;
                        TX_busy   <= 1'b1;
                        state     <= FETCH;
                    end
                end
                // Send_TX may still be high here; only IDLE looks at it
                FETCH: begin
                    FIFO_read <= 1'b0;
                    state     <= LOAD;
                end
                LOAD: begin
                    shift_reg <= FIFO_data;
                    parity_q  <= (^FIFO_data) ^ (PARITY_ODD != 0);
                    bit_cnt   <= '0;
                    TX        <= 1'b0;
                    state     <= START;
                end
                START: begin
                    if (bit_tick) begin
                        TX        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                TX    <= parity_q;
                                state <= PARITY;
                            end else begin
                                TX    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            TX        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        TX      <= 1'b1;
                        bit_cnt <= '0;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt <= '0;
                            TX_busy <= 1'b0;
                            Tx_done <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - directed and scoreboard bench for uart_tx_engine across parity/stop variants
module tb_uart_tx_engine;

    localparam int NI = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         send_w   [NI];
    logic         empty_w  [NI];
    logic         rd_w     [NI];
    logic         busy_w   [NI];
    logic         tx_w     [NI];
    logic         done_w   [NI];
    int           pops_w   [NI];
    int           rx_cnt_w [NI];
    logic [127:0] rx_bytes_w [NI];
    logic [15:0]  rx_ok_w  [NI];

    logic [7:0]   fifo_mem [NI][64];
    int           fifo_wr  [NI];
    bit           rx_en;

    int n_checks = 0;
    int n_errors = 0;

    // Instance 0: no parity, 1 stop; 1: even parity; 2: odd parity, 2 stop; 3: no parity, 2 stop
    for (genvar i = 0; i < NI; i++) begin : g_dut
        localparam int PE  = (i == 1 || i == 2) ? 1 : 0;
        localparam int ODD = (i == 2) ? 1 : 0;
        localparam int SB  = (i >= 2) ? 2 : 1;

        logic [7:0]   fdata    = 8'h00;
        int           rd       = 0;
        int           pops     = 0;
        int           rx_cnt   = 0;
        logic [127:0] rx_bytes = '0;
        logic [15:0]  rx_ok    = '0;

        uart_tx_engine #(
            .CLKS_PER_BIT(4),
            .DATA_BITS   (8),
            .PARITY_EN   (PE),
            .PARITY_ODD  (ODD),
            .STOP_BITS   (SB)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .Send_TX   (send_w[i]),
            .FIFO_empty(empty_w[i]),
            .FIFO_data (fdata),
            .FIFO_read (rd_w[i]),
            .TX_busy   (busy_w[i]),
            .TX        (tx_w[i]),
            .Tx_done   (done_w[i])
        );

        assign empty_w[i]    = (rd == fifo_wr[i]);
        assign pops_w[i]     = pops;
        assign rx_cnt_w[i]   = rx_cnt;
        assign rx_bytes_w[i] = rx_bytes;
        assign rx_ok_w[i]    = rx_ok;

        always @(posedge clk) begin
            if (rd_w[i] === 1'b1) begin
                fdata <= fifo_mem[i][rd];
                rd    <= rd + 1;
                pops  <= pops + 1;
            end
        end

        // Receiver that samples near bit centers
        initial begin : rx_model
            logic [7:0] b;
            logic       ok;
            forever begin
                @(negedge tx_w[i]);
                if (rx_en) begin
                    ok = 1'b1;
                    b  = 8'h00;
                    repeat (2) @(posedge clk);
                    #1;
                    if (tx_w[i] !== 1'b0) ok = 1'b0;
                    for (int k = 0; k < 8; k++) begin
                        repeat (4) @(posedge clk);
                        #1;
                        b[k] = tx_w[i];
                    end
                    if (PE != 0) begin
                        repeat (4) @(posedge clk);
                        #1;
                        if (tx_w[i] !== ((^b) ^ (ODD != 0))) ok = 1'b0;
                    end
                    for (int s = 0; s < SB; s++) begin
                        repeat (4) @(posedge clk);
                        #1;
                        if (tx_w[i] !== 1'b1) ok = 1'b0;
                    end
                    if (rx_cnt < 16) begin
                        rx_bytes[8*rx_cnt +: 8] = b;
                        rx_ok[rx_cnt]           = ok;
                    end
                    rx_cnt = rx_cnt + 1;
                end
            end
        end
    end

    logic rec_tx   [0:127];
    logic rec_rd   [0:127];
    logic rec_done [0:127];
    logic rec_busy [0:127];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input logic [7:0] b);
        fifo_mem[idx][fifo_wr[idx]] = b;
        fifo_wr[idx] = fifo_wr[idx] + 1;
    endtask

    // Cycle 1 is the cycle after the accepting edge
    task automatic capture(input int idx, input int ncyc, input bit hold);
        send_w[idx] = 1'b1;
        tick();
        if (!hold) send_w[idx] = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            rec_tx[c]   = tx_w[idx];
            rec_rd[c]   = rd_w[idx];
            rec_done[c] = done_w[idx];
            rec_busy[c] = busy_w[idx];
            tick();
        end
        send_w[idx] = 1'b0;
    endtask

    task automatic check_bits(input string tag, input int first, input logic [15:0] bits, input int nbits);
        logic [3:0] seen;
        for (int k = 0; k < nbits; k++) begin
            for (int j = 0; j < 4; j++) seen[j] = rec_tx[first + 4*k + j];
            check($sformatf("%s_bit%0d", tag, k), {28'd0, seen}, {28'd0, {4{bits[k]}}});
        end
    endtask

    function automatic int count_ones(input int ncyc, input bit use_done);
        int n = 0;
        for (int c = 1; c <= ncyc; c++) begin
            if (use_done ? (rec_done[c] === 1'b1) : (rec_rd[c] === 1'b1)) n++;
        end
        return n;
    endfunction

    int   p0;
    int   budget;
    bit   all_idle;
    bit   stay_ok;
    int   start_idx [NI];

    initial begin
        rst   = 1'b1;
        rx_en = 1'b0;
        for (int i = 0; i < NI; i++) begin
            send_w[i]  = 1'b0;
            fifo_wr[i] = 0;
        end

        // Reset state
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("rst_c%0d", c), {28'd0, tx_w[0], busy_w[0], rd_w[0], done_w[0]}, 32'h8);
        end
        rst = 1'b0;
        send_w[0] = 1'b1;
        stay_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (tx_w[0] !== 1'b1 || rd_w[0] !== 1'b0 || busy_w[0] !== 1'b0) stay_ok = 1'b0;
        end
        send_w[0] = 1'b0;
        check("empty_no_action", {31'd0, stay_ok}, 32'd1);
        check("empty_no_pop", pops_w[0], 0);

        // Single frame 0xA5
        push(0, 8'hA5);
        capture(0, 46, 1'b0);
        check("a5_read_n1", {31'd0, rec_rd[1]}, 32'd1);
        check("a5_busy_n1", {31'd0, rec_busy[1]}, 32'd1);
        check("a5_idle_n2", {31'd0, rec_tx[2]}, 32'd1);
        check("a5_pops", count_ones(46, 1'b0), 1);
        check_bits("a5", 3, 16'b11_0100_1010, 10);
        check("a5_done_n42", {31'd0, rec_done[42]}, 32'd0);
        check("a5_done_n43", {31'd0, rec_done[43]}, 32'd1);
        check("a5_busy_n42", {31'd0, rec_busy[42]}, 32'd1);
        check("a5_busy_n43", {31'd0, rec_busy[43]}, 32'd0);
        check("a5_done_cnt", count_ones(46, 1'b1), 1);

        // Even parity, 1 stop: 0x07 -> parity 1
        push(1, 8'h07);
        capture(1, 50, 1'b0);
        check_bits("even07", 3, 16'b110_0000_1110, 11);
        check("even07_done", {30'd0, rec_done[46], rec_done[47]}, 32'd1);

        // Odd parity, 2 stop: 0x07 -> parity 0, 8 stop cycles
        push(2, 8'h07);
        capture(2, 54, 1'b0);
        check_bits("odd07", 3, 16'b1100_0000_1110, 12);
        check("odd07_busy_n50", {31'd0, rec_busy[50]}, 32'd1);
        check("odd07_done", {30'd0, rec_done[50], rec_done[51]}, 32'd1);

        // Back-to-back with Send_TX held high
        push(0, 8'h01);
        push(0, 8'h80);
        capture(0, 92, 1'b1);
        check("b2b_pops", count_ones(92, 1'b0), 2);
        check("b2b_read_n1", {31'd0, rec_rd[1]}, 32'd1);
        check("b2b_no_pop_fetch", {30'd0, rec_rd[2], rec_rd[45]}, 32'd0);
        check("b2b_read_n44", {31'd0, rec_rd[44]}, 32'd1);
        check_bits("b2b_f1", 3, 16'b10_0000_0010, 10);
        check("b2b_gap", {29'd0, rec_tx[43], rec_tx[44], rec_tx[45]}, 32'd7);
        check_bits("b2b_f2", 46, 16'b11_0000_0000, 10);
        check("b2b_done_cnt", count_ones(92, 1'b1), 2);
        check("b2b_done_n86", {31'd0, rec_done[86]}, 32'd1);

        // Reset in the middle of data bit 3 of 0xFF
        push(0, 8'hFF);
        p0 = pops_w[0];
        send_w[0] = 1'b1;
        tick();
        send_w[0] = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        check("abort_tx_low", {31'd0, tx_w[0]}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_tx", {31'd0, tx_w[0]}, 32'd1);
        check("abort_busy", {31'd0, busy_w[0]}, 32'd0);
        stay_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) stay_ok = 1'b0;
        end
        check("abort_quiet", {31'd0, stay_ok}, 32'd1);
        check("abort_pops", pops_w[0] - p0, 1);
        push(0, 8'h3C);
        capture(0, 46, 1'b0);
        check_bits("after_rst", 3, 16'b10_0111_1000, 10);
        check("after_rst_done", {31'd0, rec_done[43]}, 32'd1);

        // Random bytes through the receiver model on every variant
        rx_en = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start_idx[i] = fifo_wr[i];
            for (int k = 0; k < 6; k++) push(i, 8'($urandom_range(0, 255)));
            send_w[i] = 1'b1;
        end
        budget   = 0;
        all_idle = 1'b0;
        while (budget < 2000 && !all_idle) begin
            tick();
            budget++;
            all_idle = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (empty_w[i] !== 1'b1 || busy_w[i] !== 1'b0) all_idle = 1'b0;
            end
        end
        check("rand_finished", {31'd0, all_idle}, 32'd1);
        for (int i = 0; i < NI; i++) send_w[i] = 1'b0;
        repeat (20) tick();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rand_u%0d_cnt", i), rx_cnt_w[i], 6);
            for (int k = 0; k < 6; k++) begin
                check($sformatf("rand_u%0d_b%0d", i, k), {24'd0, rx_bytes_w[i][8*k +: 8]},
                      {24'd0, fifo_mem[i][start_idx[i] + k]});
                check($sformatf("rand_u%0d_frame%0d", i, k), {31'd0, rx_ok_w[i][k]}, 32'd1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
